// File: rtl/lcd_hd44780_rx.sv
// lcd_hd44780_rx: receiving side of a 4-bit HD44780 LCD bus.
// The block captures nibbles on each E fall and rebuilds bytes from them.
// It decodes the instruction set and keeps a DDRAM shadow with a registered
// read port. Protocol errors raise a sticky err flag.
// Optional feature: define LCD_RX_TIMING_CHECK_EN to enable an E-high width
// check. A pulse shorter than EW_MIN cycles sets err, but the nibble is
// still accepted.
module lcd_hd44780_rx #(
    parameter int DEPTH  = 80,
    parameter int EW_MIN = 8
) (
    input  logic       qzt_clk,
    input  logic       rst_n,
    input  logic [1:0] lcd_flags,
    input  logic [3:0] lcd_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic [6:0] cursor_addr,
    output logic       mode_4bit,
    output logic       display_on,
    output logic       busy,
    output logic       err
);

    localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);
    localparam logic [7:0] BLANK     = 8'h20;

    if (DEPTH < 1 || DEPTH > 128 || EW_MIN < 1) begin : g_param_check
        $error("lcd_hd44780_rx: DEPTH must be 1..128 and EW_MIN at least 1");
    end

    typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO, CLEAR} state_t;

    state_t      state_q, state_d;
    logic        e_p0;
    logic        rs_p0;
    logic [3:0]  nib_p0;
    logic        e_fall;
    logic        width_err;
    logic [3:0]  hi_nib_q, hi_nib_d;
    logic        hi_rs_q, hi_rs_d;
    logic [6:0]  cursor_d;
    logic        id_q, id_d;
    logic        func_n_q, func_n_d;
    logic [6:0]  clr_cnt_q, clr_cnt_d;
    logic        byte_valid_d;
    logic [7:0]  byte_out_d;
    logic        byte_rs_d;
    logic        mode_d;
    logic        disp_d;
    logic        busy_d;
    logic        err_d;
    logic [7:0]  asm_byte;
    logic        we;
    logic [6:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  mem [DEPTH];

    // Move the address counter one step in the I/D direction, wrapping at both ends.
    function automatic logic [6:0] cursor_step(input logic [6:0] cur, input logic inc);
        if (inc) begin
            return (cur == LAST_ADDR) ? 7'd0 : cur + 7'd1;
        end
        return (cur == 7'd0) ? LAST_ADDR : cur - 7'd1;
    endfunction

    assign e_fall   = e_p0 & ~lcd_flags[0];
    assign asm_byte = {hi_nib_q, nib_p0};

    // ---- capture stage (p0): E history plus nibble/RS as seen while E is high ----
    // Remember last cycle's E so a fall can be seen; reset clears it so E high at release is no edge.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            e_p0 <= 1'b0;
        end else begin
            e_p0 <= lcd_flags[0];
        end
    end

    // Latch the nibble and RS while E is high; the driver drops RS together with E.
    always_ff @(posedge qzt_clk) begin
        if (lcd_flags[0]) begin
            nib_p0 <= lcd_data;
            rs_p0  <= lcd_flags[1];
        end
    end

`ifdef LCD_RX_TIMING_CHECK_EN
    localparam int              EW_W     = $clog2(EW_MIN + 1) + 1;
    localparam logic [EW_W-1:0] EW_LIMIT = EW_W'(EW_MIN);

    logic [EW_W-1:0] ew_cnt_p0;

    // Count E-high cycles, saturating so a long pulse never wraps below the limit.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            ew_cnt_p0 <= '0;
        end else if (lcd_flags[0]) begin
            if (!e_p0) begin
                ew_cnt_p0 <= EW_W'(1);
            end else if (ew_cnt_p0 != '1) begin
                ew_cnt_p0 <= ew_cnt_p0 + 1'b1;
            end
        end
    end

    assign width_err = e_fall && (ew_cnt_p0 < EW_LIMIT);
`else
    assign width_err = 1'b0;
`endif

    // ---- decode/execute stage: results register into the outputs (cycle after the fall) ----
    // Next-state and output logic for the init/nibble/clear sequencer.
    always_comb begin
        state_d      = state_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        cursor_d     = cursor_addr;
        id_d         = id_q;
        func_n_d     = func_n_q;
        clr_cnt_d    = clr_cnt_q;
        byte_valid_d = 1'b0;
        byte_out_d   = byte_out;
        byte_rs_d    = byte_rs;
        mode_d       = mode_4bit;
        disp_d       = display_on;
        busy_d       = busy;
        err_d        = err | width_err;
        we           = 1'b0;
        waddr        = cursor_addr;
        wdata        = asm_byte;

        case (state_q)
            INIT8: begin
                if (e_fall) begin
                    byte_valid_d = 1'b1;
                    byte_out_d   = {nib_p0, 4'h0};
                    byte_rs_d    = 1'b0;
                    if (nib_p0 == 4'h2) begin
                        mode_d  = 1'b1;
                        state_d = NIB_HI;
                    end else if (nib_p0 != 4'h3) begin
                        err_d = 1'b1;
                    end
                end
            end
            NIB_HI: begin
                if (e_fall) begin
                    hi_nib_d = nib_p0;
                    hi_rs_d  = rs_p0;
                    state_d  = NIB_LO;
                end
            end
            NIB_LO: begin
                if (e_fall) begin
                    byte_valid_d = 1'b1;
                    byte_out_d   = asm_byte;
                    byte_rs_d    = rs_p0;
                    state_d      = NIB_HI;
                    if (hi_rs_q != rs_p0) begin
                        err_d = 1'b1;
                    end
                    if (rs_p0) begin
                        we       = 1'b1;
                        cursor_d = cursor_step(cursor_addr, id_q);
                    end else if (asm_byte[7]) begin
                        if (asm_byte[6:0] <= LAST_ADDR) begin
                            cursor_d = asm_byte[6:0];
                        end else begin
                            cursor_d = 7'd0;
                            err_d    = 1'b1;
                        end
                    end else if (asm_byte[7:5] == 3'b001) begin
                        func_n_d = asm_byte[3];
                    end else if (asm_byte[7:3] == 5'b00001) begin
                        disp_d = asm_byte[2];
                    end else if (asm_byte[7:2] == 6'b000001) begin
                        id_d = asm_byte[1];
                    end else if (asm_byte[7:1] == 7'b0000001) begin
                        cursor_d = 7'd0;
                    end else if (asm_byte == 8'h01) begin
                        state_d   = CLEAR;
                        busy_d    = 1'b1;
                        clr_cnt_d = 7'd0;
                    end
                end
            end
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_cnt_q;
                wdata = BLANK;
                if (e_fall) begin
                    err_d = 1'b1;
                end
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d  = NIB_HI;
                    busy_d   = 1'b0;
                    cursor_d = 7'd0;
                    id_d     = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 7'd1;
                end
            end
            default: begin
                state_d = INIT8;
            end
        endcase
    end

    // Control and output registers; reset returns to INIT8 and discards a partial pair.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT8;
            cursor_addr <= 7'd0;
            id_q        <= 1'b1;
            func_n_q    <= 1'b0;
            clr_cnt_q   <= 7'd0;
            byte_valid  <= 1'b0;
            byte_out    <= 8'h00;
            byte_rs     <= 1'b0;
            mode_4bit   <= 1'b0;
            display_on  <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_addr <= cursor_d;
            id_q        <= id_d;
            func_n_q    <= func_n_d;
            clr_cnt_q   <= clr_cnt_d;
            byte_valid  <= byte_valid_d;
            byte_out    <= byte_out_d;
            byte_rs     <= byte_rs_d;
            mode_4bit   <= mode_d;
            display_on  <= disp_d;
            busy        <= busy_d;
            err         <= err_d;
        end
    end

    // High-nibble holding register; only read after a new high nibble has been taken.
    always_ff @(posedge qzt_clk) begin
        hi_nib_q <= hi_nib_d;
        hi_rs_q  <= hi_rs_d;
    end

    // DDRAM shadow write port: character writes and the clear sweep.
    always_ff @(posedge qzt_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; a same-edge write is not visible until the next read.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= (rd_addr <= LAST_ADDR) ? mem[rd_addr] : 8'h00;
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Testbench for lcd_hd44780_rx: directed and random nibble traffic checked against a byte-level model.
module tb_lcd_hd44780_rx;

    localparam int DEPTH  = 80;
    localparam int EW_MIN = 8;

    logic       qzt_clk = 1'b0;
    logic       rst_n;
    logic [1:0] lcd_flags;
    logic [3:0] lcd_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_rs;
    logic [6:0] cursor_addr;
    logic       mode_4bit;
    logic       display_on;
    logic       busy;
    logic       err;

    lcd_hd44780_rx #(.DEPTH(DEPTH), .EW_MIN(EW_MIN)) dut (
        .qzt_clk     (qzt_clk),
        .rst_n       (rst_n),
        .lcd_flags   (lcd_flags),
        .lcd_data    (lcd_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .byte_valid  (byte_valid),
        .byte_out    (byte_out),
        .byte_rs     (byte_rs),
        .cursor_addr (cursor_addr),
        .mode_4bit   (mode_4bit),
        .display_on  (display_on),
        .busy        (busy),
        .err         (err)
    );

    always #5 qzt_clk = ~qzt_clk;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;

    // Count every cycle busy is high.
    always @(negedge qzt_clk) begin
        if (busy) busy_cnt++;
    end

    // Reference model state
    logic [7:0] m_mem [DEPTH];
    int m_cur, m_id, m_disp, m_err, m_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge qzt_clk);
        #1;
    endtask

    task automatic model_reset();
        m_cur = 0; m_id = 1; m_disp = 0; m_err = 0; m_mode = 0;
    endtask

    task automatic model_byte(input logic rs, input logic [7:0] b);
        if (rs) begin
            m_mem[m_cur] = b;
            m_cur = (m_id != 0) ? (m_cur + 1) % DEPTH : (m_cur + DEPTH - 1) % DEPTH;
        end else if (b >= 8'h80) begin
            if (int'(b) - 128 < DEPTH) m_cur = int'(b) - 128;
            else begin m_cur = 0; m_err = 1; end
        end else if (b >= 8'h10) begin
            // function set, shifts and CGRAM addressing leave visible state alone
        end else if (b >= 8'h08) begin
            m_disp = int'(b[2]);
        end else if (b >= 8'h04) begin
            m_id = int'(b[1]);
        end else if (b >= 8'h02) begin
            m_cur = 0;
        end else if (b == 8'h01) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h20;
            m_cur = 0; m_id = 1;
        end
    endtask

    task automatic check_state();
        chk("cursor_addr", 32'(cursor_addr), 32'(m_cur));
        chk("err", 32'(err), 32'(m_err));
        chk("display_on", 32'(display_on), 32'(m_disp));
        chk("mode_4bit", 32'(mode_4bit), 32'(m_mode));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    // One E pulse of w cycles, then verify the byte_valid pulse one cycle after the fall.
    task automatic send_nib(input logic rs, input logic [3:0] nib, input int w,
                            input logic exp_v, input logic [7:0] exp_b, input logic exp_rs);
        lcd_flags = {rs, 1'b1};
        lcd_data  = nib;
        repeat (w) tick();
        lcd_flags = 2'b00;
        lcd_data  = 4'($urandom);
        tick();
        chk("byte_valid", 32'(byte_valid), 32'(exp_v));
        if (exp_v) begin
            chk("byte_out", 32'(byte_out), 32'(exp_b));
            chk("byte_rs", 32'(byte_rs), 32'(exp_rs));
        end
        tick();
        chk("byte_valid_pulse", 32'(byte_valid), 32'd0);
        tick();
    endtask

    task automatic send_byte(input logic rs_hi, input logic rs_lo, input logic [7:0] b, input int w);
        send_nib(rs_hi, b[7:4], w, 1'b0, 8'h00, 1'b0);
        send_nib(rs_lo, b[3:0], w, 1'b1, b, rs_lo);
    endtask

    task automatic apply(input logic rs_hi, input logic rs_lo, input logic [7:0] b, input int w);
        send_byte(rs_hi, rs_lo, b, w);
        if (rs_hi != rs_lo) m_err = 1;
`ifdef LCD_RX_TIMING_CHECK_EN
        if (w < EW_MIN) m_err = 1;
`endif
        model_byte(rs_lo, b);
        check_state();
    endtask

    // Clear display: busy must span exactly DEPTH cycles starting the cycle after the fall.
    task automatic do_clear(input int w);
        int base;
        base = busy_cnt;
        send_byte(1'b0, 1'b0, 8'h01, w);
        model_byte(1'b0, 8'h01);
        chk("busy_rise", 32'(busy), 32'd1);
        repeat (DEPTH - 3) tick();
        chk("busy_last", 32'(busy), 32'd1);
        tick();
        chk("busy_fall", 32'(busy), 32'd0);
        chk("busy_len", 32'(busy_cnt - base), 32'(DEPTH));
        check_state();
    endtask

    task automatic rd_chk(input int a);
        rd_addr = 7'(a);
        tick();
        chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(m_mem[a]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte_out", 32'(byte_out), 32'd0);
        chk("rst_byte_rs", 32'(byte_rs), 32'd0);
        chk("rst_cursor", 32'(cursor_addr), 32'd0);
        chk("rst_mode_4bit", 32'(mode_4bit), 32'd0);
        chk("rst_display_on", 32'(display_on), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        int r, w;
        logic [7:0] b;
        logic rs;

        // E held high with nibble 3 through reset release: the first fall must still be captured.
        rst_n     = 1'b0;
        lcd_flags = 2'b01;
        lcd_data  = 4'h3;
        rd_addr   = 7'd0;
        tick();
        tick();
        do_reset();

        // Power-on 8-bit init sequence 3,3,3,2
        send_nib(1'b0, 4'h3, 16, 1'b1, 8'h30, 1'b0);
        send_nib(1'b0, 4'h3, 16, 1'b1, 8'h30, 1'b0);
        send_nib(1'b0, 4'h3, 16, 1'b1, 8'h30, 1'b0);
        check_state();
        send_nib(1'b0, 4'h2, 16, 1'b1, 8'h20, 1'b0);
        m_mode = 1;
        check_state();

        // Configuration: function set, entry mode, display on, clear
        apply(1'b0, 1'b0, 8'h28, 16);
        apply(1'b0, 1'b0, 8'h06, 16);
        apply(1'b0, 1'b0, 8'h0C, 16);
        do_clear(16);
        rd_chk(0);
        rd_chk(40);
        rd_chk(79);

        // Character writes
        apply(1'b0, 1'b0, 8'h80, 10);
        apply(1'b1, 1'b1, 8'h52, 10);
        apply(1'b1, 1'b1, 8'h4D, 10);
        rd_chk(0);
        rd_chk(1);

        // Wrap-around in both directions
        apply(1'b0, 1'b0, 8'hCF, 10);
        apply(1'b1, 1'b1, 8'h41, 10);
        rd_chk(79);
        apply(1'b0, 1'b0, 8'h04, 10);
        apply(1'b1, 1'b1, 8'h42, 10);
        rd_chk(0);
        rd_chk(79);

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            r  = $urandom_range(0, 9);
            w  = $urandom_range(EW_MIN, 20);
            rs = 1'b0;
            if (r < 5) begin
                b  = 8'($urandom);
                rs = 1'b1;
            end else if (r == 5) b = 8'h80 | 8'($urandom_range(0, DEPTH - 1));
            else if (r == 6) b = 8'h04 | 8'($urandom_range(0, 3));
            else if (r == 7) b = 8'h08 | 8'($urandom_range(0, 7));
            else if (r == 8) b = 8'h02 | 8'($urandom_range(0, 1));
            else b = 8'($urandom_range(16, 127));
            apply(rs, rs, b, w);
        end
        for (int a = 0; a < DEPTH; a++) rd_chk(a);

        // E fall during clear: flagged, dropped, nibble phase unchanged
        base = busy_cnt;
        send_byte(1'b0, 1'b0, 8'h01, 8);
        model_byte(1'b0, 8'h01);
        send_nib(1'b1, 4'hA, 8, 1'b0, 8'h00, 1'b0);
        m_err = 1;
        for (int i = 0; i < 200 && busy; i++) tick();
        chk("clear_busy_done", 32'(busy), 32'd0);
        chk("clear_busy_len", 32'(busy_cnt - base), 32'(DEPTH));
        check_state();
        for (int a = 0; a < DEPTH; a++) rd_chk(a);
        apply(1'b1, 1'b1, 8'h55, 8);
        rd_chk(0);

        // Reset in the middle of a clear, then prove the state is INIT8
        send_byte(1'b0, 1'b0, 8'h01, 8);
        repeat (10) tick();
        do_reset();
        send_nib(1'b0, 4'h2, 8, 1'b1, 8'h20, 1'b0);
        m_mode = 1;
        check_state();

        // RS mismatch between nibbles: error, byte runs as a command
        apply(1'b1, 1'b0, 8'h0C, 8);

        // Out-of-range address command
        do_reset();
        send_nib(1'b0, 4'h2, 8, 1'b1, 8'h20, 1'b0);
        m_mode = 1;
        apply(1'b0, 1'b0, 8'h85, 8);
        check_state();
        apply(1'b0, 1'b0, 8'hDA, 8);

        // Illegal nibble in INIT8
        do_reset();
        send_nib(1'b0, 4'h5, 8, 1'b1, 8'h50, 1'b0);
        m_err = 1;
        check_state();
        send_nib(1'b0, 4'h2, 8, 1'b1, 8'h20, 1'b0);
        m_mode = 1;
        check_state();

        // Short E pulses: accepted, and flagged only with the width check built in
        do_reset();
        send_nib(1'b0, 4'h3, 16, 1'b1, 8'h30, 1'b0);
        send_nib(1'b0, 4'h2, 16, 1'b1, 8'h20, 1'b0);
        m_mode = 1;
        check_state();
        apply(1'b0, 1'b0, 8'h0C, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_rx.md
# lcd_hd44780_rx

Receiving end of the 4-bit HD44780 LCD bus used by the display driver. It behaves as a synthesizable controller model: it watches `lcd_flags`/`lcd_data`, reassembles nibbles into bytes and decodes the instruction set. It also maintains a DDRAM shadow that the CPU debug logic or a bench can read back, and it flags bus-protocol errors.

## Interface
- `DEPTH`, 80: DDRAM size in bytes. Valid addresses are 0..DEPTH-1; must be ≤128.
- `EW_MIN`, 8: minimum E-high width in `qzt_clk` cycles. Used only with the timing-check macro.
- `qzt_clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lcd_flags`  in  2  bit [1] = RS (1 data, 0 command), bit [0] = E.
- `lcd_data`  in  4  nibble bus.
- `rd_addr`  in  7  DDRAM read address.
- `rd_data`  out  8  DDRAM[rd_addr], registered.
- `byte_valid`  out  1  one-cycle pulse per accepted byte.
- `byte_out`  out  8  accepted byte.
- `byte_rs`  out  1  RS of the accepted byte.
- `cursor_addr`  out  7  DDRAM address counter.
- `mode_4bit`  out  1  interface switched to 4-bit mode.
- `display_on`  out  1  D bit of the last display on/off command.
- `busy`  out  1  clear display in progress.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- **Nibble capture**
  - While E=1, register `lcd_data` and RS every cycle.
  - An E fall is detected when E was 1 last cycle and is 0 now. The nibble and RS used are the values registered while E was high.
  - This is required: the driver drops RS together with E.
- **State machine:** INIT8 → NIB_HI ⇄ NIB_LO, with CLEAR entered from NIB_LO.
- **INIT8 (reset state)**
  - Each E fall yields byte {nib, 4'h0}, with RS forced to 0.
  - nib=3: stay in INIT8.
  - nib=2: set `mode_4bit`=1, go to NIB_HI.
  - Any other nib: set `err`, stay in INIT8.
- **NIB_HI:** store the high nibble and its RS, then go to NIB_LO.
- **NIB_LO**
  - Assemble {hi, lo} and use the low-nibble RS.
  - If the two RS values differ, set `err`.
  - Execute the byte, then go to NIB_HI. Clear display instead goes to CLEAR.
- **Execute, RS=1:** DDRAM[cursor]←byte, then cursor ± 1 according to I/D. The cursor wraps from DEPTH-1 to 0 and from 0 to DEPTH-1.
- **Execute, RS=0 (first match wins)**
  - 0x80|a: if a<DEPTH, cursor←a; otherwise cursor←0 and set `err`.
  - 0x20..0x3F: function set; N stored internally.
  - 0x08..0x0F: `display_on`←bit 2.
  - 0x04..0x07: I/D←bit 1.
  - 0x02..0x03: cursor←0.
  - 0x01: clear display.
  - Anything else: ignored.
- **CLEAR**
  - `busy`=1. Write 0x20 to DDRAM addresses 0..DEPTH-1, one per cycle.
  - Then cursor←0, I/D←1, `busy`=0, go to NIB_HI.
  - An E fall during CLEAR sets `err`; the nibble is dropped and nibble phase is not advanced.
- **Reset values:** all outputs 0, I/D=1, state INIT8. DDRAM contents are not reset and are undefined until the first clear.
- **Reset mid-operation** (including mid-CLEAR or between nibbles): an immediate return to INIT8. A partial nibble pair is discarded.

## Timing
- E fall detected in cycle N: `byte_valid`, `byte_out` and `byte_rs` are asserted in cycle N+1 for exactly one cycle. In 4-bit mode this applies to the low nibble only.
- The DDRAM write and the cursor update take effect at the same edge that raises `byte_valid`. `cursor_addr` is valid in N+1.
- Clear: `busy` rises in N+1 and stays high for exactly DEPTH cycles.
- `rd_data` has a 1-cycle read latency. A same-cycle write and read of one address returns the old data.
- E high at reset release is not treated as a rising edge. The first fall after release is captured.

## Configuration
- **`LCD_RX_TIMING_CHECK_EN` defined:** a counter measures each E-high period. A fall after fewer than EW_MIN high cycles sets `err`; the nibble is still accepted.
- **Not defined:** no width counter; `err` comes only from the protocol checks in Operation.

## Test plan
- **Power-on init:** nibble writes 3,3,3,2 (E high 16 cycles each, RS=0) → four `byte_valid` pulses with 0x30, 0x30, 0x30, 0x20; `mode_4bit`=1 after the fourth; `err`=0.
- **Configuration commands:** command pairs 2/8, 0/6, 0/C, 0/1 → `display_on`=1; `busy` high for 80 cycles; `rd_data`=0x20 at addresses 0, 40, 79; `cursor_addr`=0.
- **Character writes:** command 0x80, then data 0x52, 0x4D → DDRAM[0]=0x52, DDRAM[1]=0x4D, `cursor_addr`=2, `byte_rs`=1 on both.
- **Wrap-around:** command 0xCF, data 0x41 → DDRAM[79]=0x41, cursor=0. Then command 0x04, data 0x42 → DDRAM[0]=0x42, cursor=79.
- **Errors:**
  - An E fall during CLEAR → `err`=1, no `byte_valid`, DDRAM unchanged.
  - A fresh run with a pair of high-nibble RS=1 and low-nibble RS=0 → `err`=1; the byte executes as a command.
- **Timing check and reset:**
  - With the macro, E high for 4 cycles → `err`=1 and the nibble is still accepted. Without the macro → `err`=0.
  - `rst_n` low mid-CLEAR → all outputs 0 and state INIT8.
